// File: rtl/dsm_pkg.sv
// Shared constants and saturation helper for the 2nd-order delta-sigma modulator.
package dsm_pkg;

    localparam int unsigned IN_W_DEF  = 16;
    localparam int unsigned OSR_DEF   = 64;
    localparam int unsigned ACC_W_DEF = 24;

    localparam longint FS      = longint'(1) << (IN_W_DEF - 1);
    localparam longint SAT_MAX = (longint'(1) << (ACC_W_DEF - 1)) - 1;
    localparam longint SAT_MIN = -SAT_MAX;

    // Symmetric clamp to +/-(2^(acc_w-1)-1); callers truncate the result to acc_w bits.
    function automatic longint sat(input longint v, input int unsigned acc_w);
        longint lim;
        lim = (longint'(1) << (acc_w - 1)) - 1;
        if (v > lim)  return lim;
        if (v < -lim) return -lim;
        return v;
    endfunction

endpackage

// File: rtl/dsm_loop2.sv
// Two saturating integrators with 1-bit quantiser and +/-FS feedback.
module dsm_loop2
    import dsm_pkg::*;
#(
    parameter int unsigned IN_W  = IN_W_DEF,
    parameter int unsigned ACC_W = ACC_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [ACC_W-1:0] x,
    output logic                    out
);

    localparam int unsigned SW = ACC_W + 2;
    localparam logic signed [SW-1:0] FS_W = {{(SW-IN_W){1'b0}}, 1'b1, {(IN_W-1){1'b0}}};

    logic signed [ACC_W-1:0] i1, i2, i1_n, i2_n;
    logic signed [SW-1:0]    fb, s1, s2;

    // Two guard bits keep the raw sums exact before the clamp.
    always_comb begin
        fb   = out ? FS_W : -FS_W;
        s1   = {{2{i1[ACC_W-1]}}, i1} + {{2{x[ACC_W-1]}}, x} - fb;
        i1_n = ACC_W'(sat(64'(s1), ACC_W));
        s2   = {{2{i2[ACC_W-1]}}, i2} + {{2{i1_n[ACC_W-1]}}, i1_n} - fb;
        i2_n = ACC_W'(sat(64'(s2), ACC_W));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i1  <= '0;
            i2  <= '0;
            out <= 1'b0;
        end else begin
            i1  <= i1_n;
            i2  <= i2_n;
            out <= ~i2_n[ACC_W-1];
        end
    end

endmodule

// File: rtl/dsm_modulator.sv
// Delta-sigma transmit path: one-entry input buffer, OSR-cycle zero-order hold, 2nd-order loop.
module dsm_modulator
    import dsm_pkg::*;
#(
    parameter int unsigned IN_W  = IN_W_DEF,
    parameter int unsigned OSR   = OSR_DEF,
    parameter int unsigned ACC_W = ACC_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic signed [IN_W-1:0] in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   underrun_clr,
    output logic                   out,
    output logic                   frame,
    output logic                   underrun
);

    localparam int unsigned CW = $clog2(OSR);

    logic [CW-1:0]          cnt;
    logic                   buf_full;
    logic signed [IN_W-1:0] buf_data;
    logic signed [IN_W-1:0] held;
    logic                   boundary;
    logic signed [ACC_W-1:0] x_ext;

    assign boundary = (cnt == CW'(OSR - 1));
    assign in_ready = ~buf_full;
    assign x_ext    = {{(ACC_W-IN_W){held[IN_W-1]}}, held};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            buf_full <= 1'b0;
            buf_data <= '0;
            held     <= '0;
            frame    <= 1'b0;
            underrun <= 1'b0;
        end else begin
            frame <= boundary;
            cnt   <= boundary ? '0 : cnt + 1'b1;

            // A boundary with an empty buffer may still accept a new sample into the buffer.
            if (boundary && buf_full) begin
                held     <= buf_data;
                buf_full <= 1'b0;
            end else if (in_valid && !buf_full) begin
                buf_data <= in_data;
                buf_full <= 1'b1;
            end

            if (boundary && !buf_full)
                underrun <= 1'b1;
            else if (underrun_clr)
                underrun <= 1'b0;
        end
    end

    dsm_loop2 #(
        .IN_W (IN_W),
        .ACC_W(ACC_W)
    ) u_loop (
        .clk(clk),
        .rst(rst),
        .x  (x_ext),
        .out(out)
    );

endmodule

// File: tb/tb_dsm_modulator.sv
// Self-checking bench: transaction-level reference model, DC density table, handshake/underrun/reset sequences.
module tb_dsm_modulator;

    localparam int IN_W  = 16;
    localparam int OSR   = 64;
    localparam int ACC_W = 24;
    localparam longint FSV = longint'(1) << (IN_W - 1);
    localparam longint LIM = (longint'(1) << (ACC_W - 1)) - 1;

    logic                   clk = 1'b0;
    logic                   rst;
    logic signed [IN_W-1:0] in_data;
    logic                   in_valid;
    logic                   in_ready;
    logic                   underrun_clr;
    logic                   out;
    logic                   frame;
    logic                   underrun;

    int n_checks = 0;
    int n_fail   = 0;
    bit checking = 1'b0;

    dsm_modulator #(
        .IN_W (IN_W),
        .OSR  (OSR),
        .ACC_W(ACC_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .underrun_clr(underrun_clr),
        .out         (out),
        .frame       (frame),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic longint clamp(input longint v);
        if (v > LIM)  return LIM;
        if (v < -LIM) return -LIM;
        return v;
    endfunction

    // Reference model: phase as a plain counter modulo OSR, buffer as a valid flag plus value,
    // loop as integer arithmetic with clamping.
    int     m_phase;
    bit     m_full;
    int     m_buf;
    int     m_held;
    longint m_i1, m_i2;
    bit     m_out, m_frame, m_under;

    always @(posedge clk or negedge rst) begin : model
        longint fb, a, b;
        bit     bnd;
        if (!rst) begin
            m_phase <= 0; m_full <= 0; m_buf <= 0; m_held <= 0;
            m_i1 <= 0; m_i2 <= 0; m_out <= 0; m_frame <= 0; m_under <= 0;
        end else begin
            fb  = m_out ? FSV : -FSV;
            a   = clamp(m_i1 + longint'(m_held) - fb);
            b   = clamp(m_i2 + a - fb);
            bnd = (m_phase == OSR - 1);
            m_i1    <= a;
            m_i2    <= b;
            m_out   <= (b >= 0);
            m_phase <= (m_phase + 1) % OSR;
            m_frame <= bnd;
            if (underrun_clr) m_under <= 0;
            if (bnd) begin
                if (m_full) begin
                    m_held <= m_buf;
                    m_full <= 0;
                end else begin
                    m_under <= 1;
                end
            end
            if (in_valid && !m_full) begin
                m_full <= 1;
                m_buf  <= int'(in_data);
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("model_out",      out,      m_out);
            chk("model_frame",    frame,    m_frame);
            chk("model_in_ready", in_ready, !m_full);
            chk("model_underrun", underrun, m_under);
        end
    end

    task automatic wait_frame();
        bit seen = 1'b0;
        for (int i = 0; i < 2 * OSR + 2 && !seen; i++) begin
            @(negedge clk);
            seen = frame;
        end
        chk("wait_frame_timeout", seen, 1);
    endtask

    typedef struct {
        int  value;
        int  settle;
        int  cycles;
        real lo;
        real hi;
        bit  runs;
    } dc_vec_t;

    dc_vec_t vecs[5];

    initial begin
        int  first;
        int  ones, run, max_run;
        bit  prev;
        real dens;

        vecs[0] = '{0,      2 * OSR, 1024, 508.0 / 1024.0, 516.0 / 1024.0, 1'b1};
        vecs[1] = '{16384,  2 * OSR, 4096, 0.74, 0.76, 1'b0};
        vecs[2] = '{-16384, 2 * OSR, 4096, 0.24, 0.26, 1'b0};
        vecs[3] = '{32767,  2 * OSR, 2048, 0.98, 1.00, 1'b0};
        vecs[4] = '{0,      512,     1024, 0.48, 0.52, 1'b0};

        rst = 1'b0; in_valid = 1'b0; in_data = '0; underrun_clr = 1'b0;
        checking = 1'b1;

        // Reset held while inputs toggle
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rst_out", out, 0);
            chk("rst_in_ready", in_ready, 1);
            chk("rst_underrun", underrun, 0);
            chk("rst_frame", frame, 0);
            in_valid = ~in_valid;
            in_data  = IN_W'($urandom);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        first = -1;
        for (int k = 1; k <= OSR + 1 && first < 0; k++) begin
            @(negedge clk);
            if (frame) first = k;
        end
        chk("first_frame_cycle", first, OSR);

        // DC density table
        foreach (vecs[v]) begin
            in_data  = IN_W'(vecs[v].value);
            in_valid = 1'b1;
            repeat (vecs[v].settle) @(negedge clk);
            ones = 0; run = 0; max_run = 0; prev = 1'bx;
            for (int c = 0; c < vecs[v].cycles; c++) begin
                @(negedge clk);
                ones += int'(out);
                run = (c > 0 && out == prev) ? run + 1 : 1;
                if (run > max_run) max_run = run;
                prev = out;
            end
            dens = real'(ones) / real'(vecs[v].cycles);
            n_checks++;
            if (dens < vecs[v].lo || dens > vecs[v].hi) begin
                n_fail++;
                $display("FAIL density_%0d: got %f required [%f, %f]", v, dens, vecs[v].lo, vecs[v].hi);
            end
            if (vecs[v].runs) chk("max_run_le_3", max_run <= 3, 1);
        end
        in_valid = 1'b0;

        // Back-to-back handshake
        wait_frame();
        wait_frame();
        chk("hs_ready_idle", in_ready, 1);
        in_valid = 1'b1; in_data = 16'sd1234; underrun_clr = 1'b1;
        @(negedge clk);
        chk("hs_ready_low", in_ready, 0);
        chk("hs_clr", underrun, 0);
        underrun_clr = 1'b0;
        in_data = -16'sd2222;
        wait_frame();
        chk("hs_ready_after_boundary", in_ready, 1);
        chk("hs_held_first", int'(dut.held), 1234);
        @(negedge clk);
        chk("hs_second_accepted", in_ready, 0);
        in_valid = 1'b0;
        wait_frame();
        chk("hs_held_second", int'(dut.held), -2222);
        chk("hs_no_underrun", underrun, 0);

        // Underrun after last sample 1000
        in_valid = 1'b1; in_data = 16'sd1000;
        @(negedge clk);
        in_valid = 1'b0;
        wait_frame();
        chk("ur_held_1000", int'(dut.held), 1000);
        chk("ur_not_yet", underrun, 0);
        wait_frame();
        chk("ur_set", underrun, 1);
        chk("ur_held_kept", int'(dut.held), 1000);
        underrun_clr = 1'b1;
        @(negedge clk);
        underrun_clr = 1'b0;
        chk("ur_cleared", underrun, 0);
        repeat (OSR - 2) @(negedge clk);
        underrun_clr = 1'b1;
        @(negedge clk);
        underrun_clr = 1'b0;
        chk("ur_coincide_frame", frame, 1);
        chk("ur_set_wins", underrun, 1);
        chk("ur_held_still", int'(dut.held), 1000);

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            in_valid     = ($urandom_range(0, 3) != 0);
            in_data      = IN_W'($urandom);
            underrun_clr = ($urandom_range(0, 15) == 0);
        end
        underrun_clr = 1'b0;
        in_valid = 1'b1; in_data = 16'sd20000;
        repeat (OSR + 17) @(negedge clk);

        // Asynchronous reset mid-frame
        #2 rst = 1'b0;
        #1;
        chk("arst_out", out, 0);
        chk("arst_frame", frame, 0);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_underrun", underrun, 0);
        chk("arst_held", int'(dut.held), 0);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (OSR + 4) @(negedge clk);
        chk("post_rst_underrun", underrun, 1);

        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dsm_modulator.md
Name: dsm_modulator

Overview:
- Digital 2nd-order delta-sigma modulator: the transmit-side counterpart of the CIC decimation path.
- Takes signed PCM samples at the decimated rate through a valid/ready handshake.
- Holds each sample for OSR clocks (zero-order-hold interpolation) and emits a 1-bit oversampled stream at clk rate.
- The output bitstream is suitable for feeding straight back into the CIC decimator in loopback tests.

Parameters:
- IN_W, 16: signed PCM input width (two's complement).
- OSR, 64: oversampling ratio, i.e. clk cycles per held sample (≥2).
- ACC_W, 24: integrator width (> IN_W+4).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted); deassertion is synchronous to clk.
- in_data  in  IN_W  signed PCM sample.
- in_valid  in  1  in_data valid.
- in_ready  out  1  one-entry buffer empty, can accept.
- underrun_clr  in  1  clears sticky underrun flag.
- out  out  1  modulator bitstream (1 = +FS, 0 = -FS).
- frame  out  1  one-cycle pulse when the held sample is updated.
- underrun  out  1  sticky: a frame boundary found the buffer empty.

Behaviour:
- Reset values:
  - out=0, frame=0, underrun=0, in_ready=1.
  - phase counter=0, buffer empty, held sample=0, integrators i1=i2=0.
- Phase counter:
  - Counts 0..OSR-1 and wraps to 0.
  - The boundary is the cycle where cnt==OSR-1.
- Input buffer (one entry):
  - in_ready = buffer empty (registered).
  - in_valid && in_ready at a clk edge loads the buffer, and in_ready goes low next cycle.
  - in_data is ignored when in_ready=0.
- Frame boundary, buffer full:
  - held <= buffer, buffer empties, frame=1 next cycle.
  - If in_valid is high in the same cycle, it is not accepted, because in_ready was 0.
- Frame boundary, buffer empty:
  - held retains its previous value, underrun <= 1, frame=1 still pulses.
- underrun_clr clears underrun. If the clear coincides with a new underrun event, the set wins.
- Loop arithmetic (sub-module), every clk:
  - x = sign-extend(held) to ACC_W.
  - FS = 2^(IN_W-1).
  - fb = out ? +FS : -FS.
  - i1' = sat(i1 + x - fb).
  - i2' = sat(i2 + i1' - fb).
  - out' = (i2' ≥ 0).
  - Compute sums in ACC_W+2 bits; sat clamps to [-(2^(ACC_W-1)-1), 2^(ACC_W-1)-1].
  - Saturation prevents wrap-induced limit cycles on overload.
- Latency: a new held value affects out on the cycle after frame; out is registered.
- Mean of out (as ±1) equals held/FS over a frame, within modulator noise.
- Reset mid-operation: all state returns to reset values immediately; a pending buffered sample is discarded.

Decomposition:
- Package dsm_pkg:
  - IN_W/ACC_W/OSR defaults.
  - FS constant.
  - SAT_MAX/SAT_MIN constants.
  - sat() function.
- Sub-module dsm_loop2:
  - Pure loop arithmetic plus i1/i2/out registers.
  - Inputs: clk, rst, x; output: out.
- The top level holds the phase counter, buffer, handshake and flags.

Test Plan:
- Reset: hold rst=0 while toggling in_valid -> out=0, in_ready=1, underrun=0, frame=0; release -> frame first pulses at cycle OSR.
- Zero input: held=0 for 1024 cycles -> count of ones = 512 ±4, no run longer than 3 identical bits.
- DC +0.5 FS: in_data=16384 (IN_W=16), fed once per frame -> ones density 0.75 ±0.01 over 4096 cycles; -16384 -> 0.25 ±0.01.
- Handshake: two samples offered back-to-back:
  - First accepted, in_ready=0 next cycle, second not accepted.
  - in_ready returns 1 the cycle after the boundary.
  - Second sample accepted then and applied at the following boundary.
- Underrun: stop feeding after the sample value 1000 -> underrun=1 after the next boundary, held stays 1000.
  - underrun_clr pulse -> 0.
  - Clear coinciding with a boundary with an empty buffer -> stays 1.
- Overload/reset: in_data=32767 for 2048 cycles -> i1/i2 clamp (never wrap), ones density ≥0.98.
  - Then input 0 -> density back within 0.5 ±0.02 after 512 cycles.
  - Assert rst mid-frame -> all outputs at reset values within the same cycle.
